// File: rtl/spi_sram_pkg.sv
// Shared opcodes, mode-register encodings and FSM states for the 23LC512-style SPI SRAM model.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  localparam logic [7:0] MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDataRd,
    StDataWr,
    StModeRd,
    StModeWr,
    StDone
  } state_e;

endpackage

// File: rtl/spi_sram_array.sv
// Byte-wide single-port storage: synchronous write, asynchronous read, no reset so contents
// survive RESET and chip-select cycles.
module spi_sram_array
  import spi_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/spi_sram_23lc512.sv
// SPI mode-0 serial SRAM model: command/address/data FSM on SCK rising edges, read data and
// HOLD sampling on SCK falling edges, mode register for byte/page/sequential addressing.
module spi_sram_23lc512
  import spi_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PAGE_SIZE  = 32
) (
  input  logic SCK,
  input  logic RESET,
  input  logic CS_N,
  input  logic SI_SIO0,
  output logic SO_SIO1,
  input  logic HOLD_N_SIO3
);

  localparam logic [ADDR_WIDTH-1:0] PageMask = ADDR_WIDTH'(PAGE_SIZE - 1);

  state_e                  state_q;
  logic [3:0]              bit_cnt_q;
  logic [6:0]              sr_q;
  logic                    wr_op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              mode_q;
  logic [7:0]              rd_data;
  logic                    hold_q;
  logic                    so_q;
  logic                    so_en_q;
  logic                    byte_end;
  logic                    byte_mode;
  logic                    array_we;
  logic                    mode_we;
  logic [2:0]              out_idx;

  assign byte_end = (bit_cnt_q[2:0] == 3'd7);
  assign out_idx  = ~bit_cnt_q[2:0];
  assign addr_inc = addr_q + 1'b1;
  assign array_we = (state_q == StDataWr) && byte_end && !hold_q;
  assign mode_we  = (state_q == StModeWr) && byte_end && !hold_q;

  always_comb begin
    byte_mode = (mode_q[7:6] == MODE_BYTE) || (mode_q[7:6] == 2'b11);
    addr_nxt  = addr_inc;
    if (mode_q[7:6] == MODE_PAGE) begin
      addr_nxt = (addr_q & ~PageMask) | (addr_inc & PageMask);
    end
  end

  spi_sram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (SCK),
    .we   (array_we),
    .addr (addr_q),
    .wdata({sr_q, SI_SIO0}),
    .rdata(rd_data)
  );

  // CS_N high acts as a transaction-level reset; RESET additionally restores the mode register.
  always_ff @(posedge SCK or posedge RESET or posedge CS_N) begin
    if (RESET || CS_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      wr_op_q   <= 1'b0;
      addr_q    <= '0;
    end else if (!hold_q) begin
      case (state_q)
        StIdle: begin
          sr_q      <= {6'b0, SI_SIO0};
          bit_cnt_q <= 4'd1;
          state_q   <= StCmd;
        end
        StCmd: begin
          sr_q      <= {sr_q[5:0], SI_SIO0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (byte_end) begin
            bit_cnt_q <= '0;
            case ({sr_q, SI_SIO0})
              OP_READ: begin
                wr_op_q <= 1'b0;
                state_q <= StAddr;
              end
              OP_WRITE: begin
                wr_op_q <= 1'b1;
                state_q <= StAddr;
              end
              OP_RDMR: state_q <= StModeRd;
              OP_WRMR: state_q <= StModeWr;
              default: state_q <= StDone;
            endcase
          end
        end
        StAddr: begin
          addr_q    <= {addr_q[ADDR_WIDTH-2:0], SI_SIO0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_q <= '0;
            state_q   <= wr_op_q ? StDataWr : StDataRd;
          end
        end
        StDataRd, StDataWr: begin
          sr_q      <= {sr_q[5:0], SI_SIO0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (byte_end) begin
            bit_cnt_q <= '0;
            if (byte_mode) begin
              state_q <= StDone;
            end else begin
              addr_q <= addr_nxt;
            end
          end
        end
        StModeRd: bit_cnt_q <= bit_cnt_q + 4'd1;
        StModeWr: begin
          sr_q      <= {sr_q[5:0], SI_SIO0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (byte_end) begin
            state_q <= StDone;
          end
        end
        StDone: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge SCK or posedge RESET) begin
    if (RESET) begin
      mode_q <= MODE_RESET;
    end else if (mode_we) begin
      mode_q <= {sr_q[6:5], 6'b0};
    end
  end

  // A falling edge that enters HOLD does not shift; the edge that leaves HOLD drives the bit
  // that was pending, so the stream resumes without losing a bit.
  always_ff @(negedge SCK or posedge RESET or posedge CS_N) begin
    if (RESET || CS_N) begin
      hold_q  <= 1'b0;
      so_q    <= 1'b0;
      so_en_q <= 1'b0;
    end else if (!HOLD_N_SIO3) begin
      hold_q <= 1'b1;
    end else begin
      hold_q <= 1'b0;
      case (state_q)
        StDataRd: begin
          so_q    <= rd_data[out_idx];
          so_en_q <= 1'b1;
        end
        StModeRd: begin
          so_q    <= mode_q[out_idx];
          so_en_q <= 1'b1;
        end
        default: so_en_q <= 1'b0;
      endcase
    end
  end

  assign SO_SIO1 = (so_en_q && !hold_q) ? so_q : 1'bz;

endmodule

// File: tb/tb_spi_sram_23lc512.sv
// Scoreboard bench for the SPI SRAM model; SO is pulled up so a released line reads as 1.
module tb_spi_sram_23lc512;

  logic sck;
  logic rst;
  logic cs_n;
  logic si;
  logic hold_n;
  wire  so;

  pullup pu_so (so);

  spi_sram_23lc512 dut (
    .SCK        (sck),
    .RESET      (rst),
    .CS_N       (cs_n),
    .SI_SIO0    (si),
    .SO_SIO1    (so),
    .HOLD_N_SIO3(hold_n)
  );

  int n_tests;
  int n_fail;
  logic [7:0] mdl [int unsigned];
  logic [7:0] tb_mode;
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_byte_mode();
    return (tb_mode[7:6] == 2'b00) || (tb_mode[7:6] == 2'b11);
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] a);
    if (tb_mode[7:6] == 2'b10) return {a[15:5], a[4:0] + 5'd1};
    return a + 16'd1;
  endfunction

  // One SCK period: SO sampled just before the rising edge, HOLD_N updated before the fall.
  task automatic spi_bit(input logic b, input logic hold_at_fall, output logic rx);
    si = b;
    #4 rx = so;
    #1 sck = 1'b1;
    #2 hold_n = hold_at_fall;
    #3 sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], 1'b1, b);
      rx[i] = b;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #5;
  endtask

  task automatic cs_end();
    #5 cs_n = 1'b1;
    #10;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] a);
    logic [7:0] d;
    spi_byte(op, d);
    spi_byte(a[15:8], d);
    spi_byte(a[7:0], d);
  endtask

  task automatic sram_write(input logic [15:0] a, input int n, input logic [7:0] b0,
                            input logic [7:0] b1);
    logic [7:0] d;
    logic [7:0] rx;
    logic [15:0] cur;
    cur = a;
    cs_begin();
    send_hdr(8'h02, a);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? b0 : b1;
      spi_byte(d, rx);
      if (i == 0 || !tb_byte_mode()) mdl[32'(cur)] = d;
      cur = adv(cur);
    end
    cs_end();
  endtask

  task automatic sram_read(input logic [15:0] a, input int n, input string tag);
    logic [7:0] rx;
    logic [15:0] cur;
    cur = a;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && tb_byte_mode()) exp_q.push_back(8'hFF);
      else exp_q.push_back(mdl[32'(cur)]);
      cur = adv(cur);
    end
    cs_begin();
    send_hdr(8'h03, a);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      check_eq(tag, 32'(rx), 32'(exp_q.pop_front()));
    end
    cs_end();
  endtask

  task automatic wrmr(input logic [7:0] m);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h01, rx);
    spi_byte(m, rx);
    cs_end();
    tb_mode = {m[7:6], 6'b0};
  endtask

  task automatic rdmr(input string tag);
    logic [7:0] rx;
    exp_q.push_back(tb_mode);
    exp_q.push_back(tb_mode);
    cs_begin();
    spi_byte(8'h05, rx);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx);
      check_eq(tag, 32'(rx), 32'(exp_q.pop_front()));
    end
    cs_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] rx;
    logic b;
    n_tests = 0;
    n_fail  = 0;
    sck = 1'b0; si = 1'b0; cs_n = 1'b1; hold_n = 1'b1; rst = 1'b1;
    tb_mode = 8'h40;
    #20 rst = 1'b0;
    #5 check_eq("reset_so_z", 32'(so), 32'd1);
    rdmr("reset_mode");

    // Known background for the "unchanged" checks
    sram_write(16'h0020, 1, 8'h5C, 8'h00);
    sram_write(16'h0101, 1, 8'h3C, 8'h00);
    sram_write(16'h0200, 1, 8'hC3, 8'h00);

    sram_write(16'h0010, 2, 8'hA5, 8'h5A);
    sram_read(16'h0010, 2, "seq_read");

    sram_write(16'hFFFF, 2, 8'h11, 8'h22);
    sram_read(16'hFFFF, 2, "seq_wrap");
    sram_read(16'h0000, 1, "seq_wrap_0");

    wrmr(8'h80);
    sram_write(16'h001F, 2, 8'h33, 8'h44);
    sram_read(16'h0000, 1, "page_wrap");
    sram_read(16'h0020, 1, "page_next_untouched");
    rdmr("rdmr_page");

    wrmr(8'h00);
    sram_write(16'h0100, 2, 8'h77, 8'h88);
    sram_read(16'h0101, 1, "byte_no_advance");
    sram_read(16'h0100, 2, "byte_read_then_z");

    cs_begin();
    send_hdr(8'h02, 16'h0200);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1, b);
    cs_end();
    sram_read(16'h0200, 1, "abort_unchanged");

    wrmr(8'h80);
    exp_q.push_back(mdl[32'h0010]);
    exp_q.push_back(mdl[32'h0011]);
    cs_begin();
    send_hdr(8'h03, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      spi_bit(1'b0, 1'b1, b);
      r[7-i] = b;
    end
    spi_bit(1'b0, 1'b0, b);
    r[4] = b;
    for (int k = 0; k < 3; k++) begin
      spi_bit(1'b0, 1'b0, b);
      check_eq("hold_so_z", 32'(b), 32'd1);
    end
    spi_bit(1'b0, 1'b1, b);
    check_eq("hold_so_z", 32'(b), 32'd1);
    for (int i = 4; i < 8; i++) begin
      spi_bit(1'b0, 1'b1, b);
      r[7-i] = b;
    end
    check_eq("hold_byte0", 32'(r), 32'(exp_q.pop_front()));
    spi_byte(8'h00, rx);
    check_eq("hold_byte1", 32'(rx), 32'(exp_q.pop_front()));
    rst = 1'b1;
    #5 rst = 1'b0;
    cs_end();
    tb_mode = 8'h40;
    rdmr("reset_mode_restore");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
